// File: rtl/cnnip_cmd_sequencer.sv
// cnnip_cmd_sequencer
// Bus master that programs one CNN layer configuration into the CNN IP
// register block, starts the engine and polls DONE until completion or
// timeout. The result goes upstream as busy, a done pulse, a timeout flag
// and the measured run length.
//
// Register map (byte offsets):
//   0x0 START   all-ones = start, 0 = stop
//   0x4 DONE    all-ones = done
//   0x8 CFG_A   {8'h0, kernel_size, 8'h0, kernel_nums}
//   0xC CFG_B   {15'h0, padding, 14'h0, stride}
//
// All outputs are registered. Each access is driven on the edge that enters
// the state issuing it, so the access appears on the bus during that
// state's cycle.

module cnnip_cmd_sequencer #(
    parameter int POLL_GAP       = 4,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int TO_W           = 24
) (
    input  logic            clk_a,
    input  logic            srst_aq,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [7:0]      req_kernel_size,
    input  logic [7:0]      req_kernel_nums,
    input  logic [1:0]      req_stride,
    input  logic            req_padding,
    output logic            mem_en,
    output logic [3:0]      mem_we,
    output logic [3:0]      mem_addr,
    output logic [31:0]     mem_din,
    input  logic [31:0]     mem_dout,
    input  logic            mem_valid,
    output logic            busy,
    output logic            done,
    output logic            err_timeout,
    output logic [TO_W-1:0] run_cycles
);

    localparam int GAP_W = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

    localparam logic [3:0] ADDR_START = 4'h0;
    localparam logic [3:0] ADDR_DONE  = 4'h4;
    localparam logic [3:0] ADDR_CFG_A = 4'h8;
    localparam logic [3:0] ADDR_CFG_B = 4'hC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_CFGA,
        S_WR_CFGB,
        S_CLR_DONE,
        S_WR_START,
        S_POLL,
        S_ABORT,
        S_DONE
    } state_t;

    state_t          state;
    logic [7:0]      kernel_nums_q;
    logic [7:0]      kernel_size_q;
    logic [1:0]      stride_q;
    logic            padding_q;
    logic [TO_W-1:0] run_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic [31:0]     cfg_a_word;
    logic [31:0]     cfg_b_word;
    logic [TO_W-1:0] run_inc;
    logic [GAP_W-1:0] gap_nxt;
    logic            poll_read;
    logic            done_seen;
    logic            timeout_hit;

    // Poll bookkeeping and configuration words derived from the current cycle.
    // NOTE: every always_comb output gets a value on every path; here each is
    // a plain unconditional assignment, so no latch can be inferred.
    always_comb begin
        cfg_a_word  = {8'h00, req_kernel_size, 8'h00, req_kernel_nums};
        cfg_b_word  = {15'h0000, padding_q, 14'h0000, stride_q};
        run_inc     = run_cnt + 1'b1;
        poll_read   = (gap_cnt == '0);
        gap_nxt     = poll_read ? GAP_W'(POLL_GAP) : gap_cnt - 1'b1;
        // An intermediate DONE value (nonzero, not all-ones) is not completion.
        done_seen   = poll_read && mem_valid && (&mem_dout);
        timeout_hit = (run_inc == TO_W'(TIMEOUT_CYCLES));
    end

    // Command FSM with registered upstream flags and registered bus outputs.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_a) begin
        if (srst_aq) begin
            state         <= S_IDLE;
            req_ready     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_timeout   <= 1'b0;
            run_cycles    <= '0;
            run_cnt       <= '0;
            gap_cnt       <= '0;
            kernel_size_q <= '0;
            kernel_nums_q <= '0;
            stride_q      <= '0;
            padding_q     <= 1'b0;
            mem_en        <= 1'b0;
            mem_we        <= 4'h0;
            mem_addr      <= 4'h0;
            mem_din       <= 32'h0;
        end else begin
            // Bus idles and done drops unless the next state drives them.
            mem_en   <= 1'b0;
            mem_we   <= 4'h0;
            mem_addr <= 4'h0;
            mem_din  <= 32'h0;
            done     <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        kernel_size_q <= req_kernel_size;
                        kernel_nums_q <= req_kernel_nums;
                        stride_q      <= req_stride;
                        padding_q     <= req_padding;
                        err_timeout   <= 1'b0;
                        req_ready     <= 1'b0;
                        busy          <= 1'b1;
                        state         <= S_WR_CFGA;
                        mem_en        <= 1'b1;
                        mem_we        <= 4'hF;
                        mem_addr      <= ADDR_CFG_A;
                        mem_din       <= cfg_a_word;
                    end
                end

                S_WR_CFGA: begin
                    state    <= S_WR_CFGB;
                    mem_en   <= 1'b1;
                    mem_we   <= 4'hF;
                    mem_addr <= ADDR_CFG_B;
                    mem_din  <= cfg_b_word;
                end

                S_WR_CFGB: begin
                    state    <= S_CLR_DONE;
                    mem_en   <= 1'b1;
                    mem_we   <= 4'hF;
                    mem_addr <= ADDR_DONE;
                    mem_din  <= 32'h0;
                end

                S_CLR_DONE: begin
                    state    <= S_WR_START;
                    mem_en   <= 1'b1;
                    mem_we   <= 4'hF;
                    mem_addr <= ADDR_START;
                    mem_din  <= 32'hFFFF_FFFF;
                end

                S_WR_START: begin
                    // Counters start from zero so the first POLL cycle reads.
                    state    <= S_POLL;
                    run_cnt  <= '0;
                    gap_cnt  <= '0;
                    mem_en   <= 1'b1;
                    mem_addr <= ADDR_DONE;
                end

                S_POLL: begin
                    run_cnt <= run_inc;
                    gap_cnt <= gap_nxt;
                    if (done_seen) begin
                        run_cycles <= run_inc;
                        done       <= 1'b1;
                        state      <= S_DONE;
                    end else if (timeout_hit) begin
                        state    <= S_ABORT;
                        mem_en   <= 1'b1;
                        mem_we   <= 4'hF;
                        mem_addr <= ADDR_START;
                        mem_din  <= 32'h0;
                    end else if (gap_nxt == '0) begin
                        mem_en   <= 1'b1;
                        mem_addr <= ADDR_DONE;
                    end
                end

                S_ABORT: begin
                    run_cycles  <= TO_W'(TIMEOUT_CYCLES);
                    err_timeout <= 1'b1;
                    done        <= 1'b1;
                    state       <= S_DONE;
                end

                S_DONE: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end

                default: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
